// File: rtl/hyperbus_resp_phy.sv
// Device-side HyperBus responder PHY: CA decode, latency counting, linear/wrapped bursts,
// bridged to a req/gnt + rvalid memory port. Link side is one 16-bit word per ck_valid_i.
module hyperbus_resp_phy #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned LatCycles = 6,
    parameter int unsigned WrapWords = 16,
    parameter int unsigned FifoDepth = 4,
    parameter logic [15:0] RegValue  = 16'h8F1F
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cs_ni,
    input  logic                 ck_valid_i,
    input  logic [15:0]          dq_i,
    input  logic [1:0]           rwds_i,
    input  logic                 add_lat_i,
    output logic [15:0]          dq_o,
    output logic                 dq_oe_o,
    output logic                 dq_valid_o,
    output logic                 rwds_o,
    output logic                 rwds_oe_o,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [15:0]          mem_wdata_o,
    output logic [1:0]           mem_be_o,
    input  logic                 mem_rvalid_i,
    input  logic [15:0]          mem_rdata_i,
    output logic                 reg_wr_o,
    output logic [15:0]          reg_wdata_o,
    output logic                 error_o
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned LatW = $clog2(2 * LatCycles + 1);
    localparam logic [AddrWidth-1:0] WrapMask = AddrWidth'(WrapWords - 1);

    typedef enum logic [2:0] {StIdle, StCa, StLatency, StWrite, StRead, StDrain} state_e;

    state_e               state_q;
    logic [31:0]          ca_q;
    logic [1:0]           ca_cnt_q;
    logic [LatW-1:0]      lat_q;
    logic                 is_rd_q, is_reg_q, is_lin_q;
    logic                 wr_mode_q, rd_active_q, dq_oe_q, rwds_oe_q;
    logic [AddrWidth-1:0] addr_q, rd_addr_q;

    // Write buffer: {addr, data, byte enables}
    logic [AddrWidth-1:0] wf_addr [FifoDepth];
    logic [15:0]          wf_data [FifoDepth];
    logic [1:0]           wf_be   [FifoDepth];
    logic [PtrW-1:0]      wf_wptr_q, wf_rptr_q;
    logic [CntW-1:0]      wf_cnt_q;

    // Read prefetch buffer and count of granted-but-unreturned reads
    logic [15:0]          rf_data [FifoDepth];
    logic [PtrW-1:0]      rf_wptr_q, rf_rptr_q;
    logic [CntW-1:0]      rf_cnt_q;
    logic [CntW-1:0]      os_cnt_q;

    logic [47:0]          ca_full;
    logic [31:0]          ca_addr32;
    logic [AddrWidth-1:0] ca_addr;
    logic                 leave, wf_push, wf_drop, wf_pop, rd_fire, rf_push, rf_pop, os_dec;
    logic                 wf_head_vld, rd_credit;

    function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] a,
                                                       input logic lin);
        logic [AddrWidth-1:0] inc;
        inc = a + AddrWidth'(1);
        if (lin) return inc;
        return (a & ~WrapMask) | (inc & WrapMask);
    endfunction

    assign ca_full   = {ca_q, dq_i};
    assign ca_addr32 = {ca_full[44:16], ca_full[2:0]};
    assign ca_addr   = AddrWidth'(ca_addr32);

    assign wf_head_vld = wr_mode_q && (wf_cnt_q != '0);
    assign rd_credit   = ({1'b0, os_cnt_q} + {1'b0, rf_cnt_q}) < (CntW + 1)'(FifoDepth);
    assign mem_req_o   = wr_mode_q ? (wf_cnt_q != '0) : (rd_active_q && rd_credit);
    assign mem_we_o    = wr_mode_q;
    assign mem_addr_o  = wf_head_vld ? wf_addr[wf_rptr_q] : rd_addr_q;
    assign mem_wdata_o = wf_head_vld ? wf_data[wf_rptr_q] : 16'h0000;
    assign mem_be_o    = wf_head_vld ? wf_be[wf_rptr_q] : 2'b00;

    // Output enables drop combinationally so the bus is released in the cycle CS rises
    assign dq_oe_o   = dq_oe_q & ~cs_ni;
    assign rwds_oe_o = rwds_oe_q & ~cs_ni;

    // Per-cycle FIFO and handshake strobes
    always_comb begin
        leave   = cs_ni && (state_q inside {StCa, StLatency, StWrite, StRead});
        wf_push = (state_q == StWrite) && ck_valid_i && !is_reg_q &&
                  (wf_cnt_q != CntW'(FifoDepth));
        wf_drop = (state_q == StWrite) && ck_valid_i && !is_reg_q &&
                  (wf_cnt_q == CntW'(FifoDepth));
        wf_pop  = mem_req_o && mem_gnt_i && wr_mode_q;
        rd_fire = mem_req_o && mem_gnt_i && !wr_mode_q;
        os_dec  = mem_rvalid_i && (os_cnt_q != '0);
        // Late rvalids while draining are counted off but never stored
        rf_push = os_dec && !leave && (state_q inside {StLatency, StRead});
        rf_pop  = (state_q == StRead) && ck_valid_i && !is_reg_q && (rf_cnt_q != '0);
    end

    // Access FSM with registered link-side outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            ca_q        <= '0;
            ca_cnt_q    <= '0;
            lat_q       <= '0;
            is_rd_q     <= 1'b0;
            is_reg_q    <= 1'b0;
            is_lin_q    <= 1'b0;
            wr_mode_q   <= 1'b0;
            rd_active_q <= 1'b0;
            dq_oe_q     <= 1'b0;
            rwds_oe_q   <= 1'b0;
            rwds_o      <= 1'b0;
            addr_q      <= '0;
            rd_addr_q   <= '0;
            dq_o        <= '0;
            dq_valid_o  <= 1'b0;
            reg_wr_o    <= 1'b0;
            reg_wdata_o <= '0;
            error_o     <= 1'b0;
        end else begin
            dq_valid_o <= 1'b0;
            reg_wr_o   <= 1'b0;
            if (wf_drop) error_o <= 1'b1;
            if (rd_fire) rd_addr_q <= next_addr(rd_addr_q, is_lin_q);

            unique case (state_q)
                StIdle: begin
                    if (!cs_ni) begin
                        state_q   <= StCa;
                        ca_cnt_q  <= '0;
                        rwds_o    <= add_lat_i;
                        rwds_oe_q <= 1'b1;
                    end
                end
                StCa: begin
                    if (ck_valid_i) begin
                        ca_q     <= ca_full[31:0];
                        ca_cnt_q <= ca_cnt_q + 2'd1;
                        if (ca_cnt_q == 2'd2) begin
                            is_rd_q  <= ca_full[47];
                            is_reg_q <= ca_full[46];
                            is_lin_q <= ca_full[45];
                            addr_q   <= ca_addr;
                            lat_q    <= rwds_o ? LatW'(2 * LatCycles) : LatW'(LatCycles);
                            if (ca_full[46] && !ca_full[47]) begin
                                state_q <= StWrite;
                            end else begin
                                state_q <= StLatency;
                                if (ca_full[47] && !ca_full[46]) begin
                                    rd_active_q <= 1'b1;
                                    rd_addr_q   <= ca_addr;
                                end
                                if (!ca_full[47] && !ca_full[46]) wr_mode_q <= 1'b1;
                            end
                        end
                    end
                end
                StLatency: begin
                    if (ck_valid_i) begin
                        if (lat_q == LatW'(1)) begin
                            state_q <= is_rd_q ? StRead : StWrite;
                            if (is_rd_q) dq_oe_q <= 1'b1;
                        end else begin
                            lat_q <= lat_q - LatW'(1);
                        end
                    end
                end
                StWrite: begin
                    if (ck_valid_i) begin
                        addr_q <= next_addr(addr_q, is_lin_q);
                        if (is_reg_q) begin
                            reg_wr_o    <= 1'b1;
                            reg_wdata_o <= dq_i;
                        end
                    end
                end
                StRead: begin
                    if (ck_valid_i) begin
                        // Empty FIFO leaves dq_valid_o low: the controller sees an RWDS stall
                        if (is_reg_q) begin
                            dq_o       <= RegValue;
                            dq_valid_o <= 1'b1;
                        end else if (rf_cnt_q != '0) begin
                            dq_o       <= rf_data[rf_rptr_q];
                            dq_valid_o <= 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if ((os_cnt_q == '0) && (wf_cnt_q == '0)) begin
                        state_q   <= StIdle;
                        wr_mode_q <= 1'b0;
                        rwds_o    <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // CS deassertion overrides; a word arriving in the same cycle was handled above
            if (leave) begin
                state_q     <= StDrain;
                rd_active_q <= 1'b0;
                dq_oe_q     <= 1'b0;
                rwds_oe_q   <= 1'b0;
            end
        end
    end

    // FIFO pointers, occupancies and outstanding-read count
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wf_wptr_q <= '0;
            wf_rptr_q <= '0;
            wf_cnt_q  <= '0;
            rf_wptr_q <= '0;
            rf_rptr_q <= '0;
            rf_cnt_q  <= '0;
            os_cnt_q  <= '0;
        end else begin
            if (wf_push) wf_wptr_q <= wf_wptr_q + PtrW'(1);
            if (wf_pop)  wf_rptr_q <= wf_rptr_q + PtrW'(1);
            wf_cnt_q <= wf_cnt_q + CntW'(wf_push) - CntW'(wf_pop);
            os_cnt_q <= os_cnt_q + CntW'(rd_fire) - CntW'(os_dec);
            if (leave) begin
                rf_wptr_q <= '0;
                rf_rptr_q <= '0;
                rf_cnt_q  <= '0;
            end else begin
                if (rf_push) rf_wptr_q <= rf_wptr_q + PtrW'(1);
                if (rf_pop)  rf_rptr_q <= rf_rptr_q + PtrW'(1);
                rf_cnt_q <= rf_cnt_q + CntW'(rf_push) - CntW'(rf_pop);
            end
        end
    end

    // FIFO storage; validity is tracked entirely by the pointers above
    always_ff @(posedge clk_i) begin
        if (wf_push) begin
            wf_addr[wf_wptr_q] <= addr_q;
            wf_data[wf_wptr_q] <= dq_i;
            wf_be[wf_wptr_q]   <= ~rwds_i;
        end
        if (rf_push) rf_data[rf_wptr_q] <= mem_rdata_i;
    end

endmodule

// File: tb/tb_hyperbus_resp_phy.sv
// Directed bench for hyperbus_resp_phy with a one-cycle-latency memory model.
module tb_hyperbus_resp_phy;

    logic        clk_i = 1'b0;
    logic        rst_ni, cs_ni, ck_valid_i, add_lat_i;
    logic [15:0] dq_i;
    logic [1:0]  rwds_i;
    logic [15:0] dq_o;
    logic        dq_oe_o, dq_valid_o, rwds_o, rwds_oe_o;
    logic        mem_req_o, mem_gnt_i, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic [1:0]  mem_be_o;
    logic        mem_rvalid_i = 1'b0;
    logic [15:0] mem_rdata_i = 16'h0000;
    logic        reg_wr_o;
    logic [15:0] reg_wdata_o;
    logic        error_o;
    logic        gnt_en;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    assign mem_gnt_i = gnt_en & mem_req_o;

    hyperbus_resp_phy dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cs_ni        (cs_ni),
        .ck_valid_i   (ck_valid_i),
        .dq_i         (dq_i),
        .rwds_i       (rwds_i),
        .add_lat_i    (add_lat_i),
        .dq_o         (dq_o),
        .dq_oe_o      (dq_oe_o),
        .dq_valid_o   (dq_valid_o),
        .rwds_o       (rwds_o),
        .rwds_oe_o    (rwds_oe_o),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .reg_wr_o     (reg_wr_o),
        .reg_wdata_o  (reg_wdata_o),
        .error_o      (error_o)
    );

    // Memory model and output monitors; rdata equals the low 16 address bits
    int          seen = 0;
    int          rd_cnt = 0, rd_n = 0, wr_n = 0, regw_cnt = 0, regw_idx = 0;
    logic [15:0] rdq [0:127];
    int          rdi [0:127];
    logic [31:0] rda [0:127];
    logic [31:0] wra [0:127];
    logic [15:0] wrd [0:127];
    logic [1:0]  wrb [0:127];
    logic [15:0] regw_data = 16'h0000;

    always @(posedge clk_i) begin
        if (ck_valid_i) seen <= seen + 1;
        mem_rvalid_i <= mem_req_o && mem_gnt_i && !mem_we_o;
        mem_rdata_i  <= mem_addr_o[15:0];
        if (mem_req_o && mem_gnt_i) begin
            if (mem_we_o) begin
                wra[wr_n] <= mem_addr_o;
                wrd[wr_n] <= mem_wdata_o;
                wrb[wr_n] <= mem_be_o;
                wr_n      <= wr_n + 1;
            end else begin
                rda[rd_n] <= mem_addr_o;
                rd_n      <= rd_n + 1;
            end
        end
        if (dq_valid_o) begin
            rdq[rd_cnt] <= dq_o;
            rdi[rd_cnt] <= seen;
            rd_cnt      <= rd_cnt + 1;
        end
        if (reg_wr_o) begin
            regw_cnt  <= regw_cnt + 1;
            regw_data <= reg_wdata_o;
            regw_idx  <= seen;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] mk_ca(input logic rd, input logic rg, input logic lin,
                                          input logic [31:0] a);
        mk_ca = {rd, rg, lin, a[31:3], 13'd0, a[2:0]};
    endfunction

    task automatic word(input logic [15:0] d, input logic [1:0] m);
        @(negedge clk_i);
        ck_valid_i = 1'b1;
        dq_i       = d;
        rwds_i     = m;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            ck_valid_i = 1'b0;
        end
    endtask

    task automatic start(input logic al);
        @(negedge clk_i);
        ck_valid_i = 1'b0;
        cs_ni      = 1'b0;
        add_lat_i  = al;
    endtask

    task automatic stop();
        @(negedge clk_i);
        ck_valid_i = 1'b0;
        cs_ni      = 1'b1;
    endtask

    task automatic send_ca(input logic [47:0] ca);
        word(ca[47:32], 2'b00);
        word(ca[31:16], 2'b00);
        word(ca[15:0], 2'b00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, rb, mb, wb;
        rst_ni = 1'b0; cs_ni = 1'b1; ck_valid_i = 1'b0; add_lat_i = 1'b0;
        dq_i = 16'h0000; rwds_i = 2'b00; gnt_en = 1'b1;
        idle(3);
        chk("reset_outputs", {dq_o, dq_oe_o, dq_valid_o, rwds_o, rwds_oe_o, mem_req_o, mem_we_o,
                              reg_wr_o, reg_wdata_o, error_o}, 64'd0);
        chk("reset_mem_port", {mem_addr_o, mem_wdata_o, mem_be_o}, 64'd0);
        rst_ni = 1'b1;
        idle(2);

        // Linear read at 0x10
        base = seen; rb = rd_cnt; mb = rd_n;
        start(1'b0);
        send_ca(mk_ca(1'b1, 1'b0, 1'b1, 32'h10));
        chk("rd_rwds_oe", rwds_oe_o, 1'b1);
        chk("rd_rwds_lvl", rwds_o, 1'b0);
        repeat (6) word(16'hFFFF, 2'b00);
        repeat (4) word(16'h0000, 2'b00);
        idle(2);
        chk("rd_count", rd_cnt - rb, 4);
        chk("rd_first_idx", rdi[rb] - base, 10);
        for (int i = 0; i < 4; i++) chk("rd_data", rdq[rb+i], 16'h10 + 16'(i));
        chk("rd_oe_on", dq_oe_o, 1'b1);
        @(negedge clk_i);
        cs_ni = 1'b1;
        #1;
        chk("rd_oe_off_same_cycle", {dq_oe_o, rwds_oe_o}, 2'b00);
        idle(8);
        chk("rd_idle_noreq", mem_req_o, 1'b0);
        for (int i = 0; i < 4; i++) chk("rd_mem_addr", rda[mb+i], 32'h10 + 32'(i));

        // Wrapped read at 0x1E
        rb = rd_cnt; mb = rd_n;
        start(1'b0);
        send_ca(mk_ca(1'b1, 1'b0, 1'b0, 32'h1E));
        repeat (6) word(16'hFFFF, 2'b00);
        repeat (4) word(16'h0000, 2'b00);
        idle(2);
        stop();
        idle(8);
        chk("wrap_count", rd_cnt - rb, 4);
        chk("wrap_mem_a0", rda[mb],   32'h1E);
        chk("wrap_mem_a1", rda[mb+1], 32'h1F);
        chk("wrap_mem_a2", rda[mb+2], 32'h10);
        chk("wrap_mem_a3", rda[mb+3], 32'h11);
        chk("wrap_dq2", rdq[rb+2], 16'h10);
        chk("wrap_dq3", rdq[rb+3], 16'h11);

        // Linear write of two words with a masked upper byte on the first
        wb = wr_n;
        start(1'b0);
        send_ca(mk_ca(1'b0, 1'b0, 1'b1, 32'h40));
        repeat (6) word(16'hDEAD, 2'b00);
        word(16'h1234, 2'b10);
        word(16'hABCD, 2'b00);
        idle(1);
        stop();
        idle(8);
        chk("wr_count", wr_n - wb, 2);
        chk("wr_w0", {wra[wb], wrd[wb], wrb[wb]}, {32'h40, 16'h1234, 2'b01});
        chk("wr_w1", {wra[wb+1], wrd[wb+1], wrb[wb+1]}, {32'h41, 16'hABCD, 2'b11});

        // Register write: zero latency, no memory traffic
        base = seen; wb = wr_n + rd_n; rb = regw_cnt;
        start(1'b0);
        send_ca(mk_ca(1'b0, 1'b1, 1'b1, 32'h0));
        word(16'h8F17, 2'b00);
        idle(2);
        stop();
        idle(4);
        chk("regw_pulses", regw_cnt - rb, 1);
        chk("regw_data", regw_data, 16'h8F17);
        chk("regw_idx", regw_idx - base, 4);
        chk("regw_no_mem", wr_n + rd_n, wb);

        // Write buffer overflow with grant held low
        wb = wr_n;
        gnt_en = 1'b0;
        start(1'b0);
        send_ca(mk_ca(1'b0, 1'b0, 1'b1, 32'h80));
        repeat (6) word(16'hDEAD, 2'b00);
        for (int i = 0; i < 6; i++) word(16'h5000 + 16'(i), 2'b00);
        idle(2);
        chk("ovf_error", error_o, 1'b1);
        chk("ovf_no_grant", wr_n - wb, 0);
        stop();
        gnt_en = 1'b1;
        idle(10);
        chk("ovf_drained", wr_n - wb, 4);
        for (int i = 0; i < 4; i++)
            chk("ovf_entry", {wra[wb+i], wrd[wb+i]}, {32'h80 + 32'(i), 16'h5000 + 16'(i)});
        chk("ovf_error_sticky", error_o, 1'b1);

        // Doubled latency read, CS rises together with the second data word
        base = seen; rb = rd_cnt;
        start(1'b1);
        send_ca(mk_ca(1'b1, 1'b0, 1'b1, 32'h20));
        chk("dbl_rwds_lvl", {rwds_oe_o, rwds_o}, 2'b11);
        repeat (12) word(16'hFFFF, 2'b00);
        word(16'h0000, 2'b00);
        @(negedge clk_i);
        ck_valid_i = 1'b1;
        cs_ni      = 1'b1;
        idle(10);
        chk("dbl_count", rd_cnt - rb, 2);
        chk("dbl_first_idx", rdi[rb] - base, 16);
        chk("dbl_data", {rdq[rb], rdq[rb+1]}, {16'h20, 16'h21});
        chk("dbl_idle_noreq", mem_req_o, 1'b0);

        // Next read must not see any stale prefetched or late data
        rb = rd_cnt;
        start(1'b0);
        send_ca(mk_ca(1'b1, 1'b0, 1'b1, 32'h50));
        repeat (6) word(16'hFFFF, 2'b00);
        word(16'h0000, 2'b00);
        idle(2);
        stop();
        idle(8);
        chk("after_drain_data", {rd_cnt - rb, 16'(rdq[rb])}, {32'd1, 16'h50});

        // Register read returns the fixed value and touches no memory
        rb = rd_cnt; mb = rd_n;
        start(1'b0);
        send_ca(mk_ca(1'b1, 1'b1, 1'b1, 32'h0));
        repeat (6) word(16'hFFFF, 2'b00);
        repeat (2) word(16'h0000, 2'b00);
        idle(2);
        stop();
        idle(6);
        chk("regr_data", {rd_cnt - rb, 16'(rdq[rb]), 16'(rdq[rb+1])},
            {32'd2, 16'h8F1F, 16'h8F1F});
        chk("regr_no_mem", rd_n - mb, 0);

        // Reset in the middle of a prefetching read
        start(1'b0);
        send_ca(mk_ca(1'b1, 1'b0, 1'b1, 32'h60));
        repeat (2) word(16'hFFFF, 2'b00);
        chk("mid_req_active", mem_req_o, 1'b1);
        chk("mid_error_before", error_o, 1'b1);
        @(negedge clk_i);
        rst_ni     = 1'b0;
        cs_ni      = 1'b1;
        ck_valid_i = 1'b0;
        @(negedge clk_i);
        chk("mid_reset_outs", {mem_req_o, rwds_oe_o, dq_oe_o, error_o}, 4'b0000);
        rst_ni = 1'b1;
        idle(4);
        chk("mid_reset_idle", {mem_req_o, dq_valid_o}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
